triangle_setup: RTL
===================

# triangle_setup

Triangle assembly and setup stage directly downstream of the geometry engine's vertex FIFO. Pops screen-space vertices three at a time and computes the signed area, three edge-function coefficient sets and a screen-clamped bounding box. Drops degenerate, off-screen and guard-band-violating triangles. Hands each surviving triangle to the rasterizer over a valid/ready handshake.

## Interface
- `SCREEN_W`, default 320: horizontal resolution in pixels.
- `SCREEN_H`, default 240: vertical resolution in pixels.
- `GUARD_BAND`, default 2048: a vertex is rejected if the magnitude of its integer coordinate is ≥ this value.
- `i_clk` in 1: the only clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_flush` in 1: discards any partially collected triangle; used at frame start.
- `i_fifo_empty` in 1: vertex FIFO empty. The FIFO is first-word-fall-through.
- `o_fifo_rd` in/out: out 1: pop strobe; combinational.
- `i_vtx_x`, `i_vtx_y` in 32: Q16.16 screen coordinates. The integer part is `[31:16]`, signed.
- `i_vtx_z` in 8: depth.
- `i_vtx_u`, `i_vtx_v` in 32: texture coordinates, passed through untouched.
- `o_tri_valid` out 1: triangle available.
- `i_tri_ready` in 1: rasterizer accepts the triangle.
- `o_bbox_xmin`, `o_bbox_xmax` out 9: clamped pixel X bounds, inclusive.
- `o_bbox_ymin`, `o_bbox_ymax` out 8: clamped pixel Y bounds, inclusive.
- `o_edge_a`, `o_edge_b` out [2:0][15:0]: signed edge coefficients.
- `o_edge_c` out [2:0][31:0]: signed edge coefficients.
- `o_area` out 32: signed doubled area. Always > 0 when `o_tri_valid` is high.
- `o_z` out [2:0][7:0]; `o_u`, `o_v` out [2:0][31:0]: per-vertex attributes, in output vertex order.
- `o_culled_count` out 16: saturating count of dropped triangles.
- `o_busy` out 1: high in any state other than S_COLLECT, or while the vertex count is nonzero.

## Operation
- **Integer coordinates:** `xi = i_vtx_x[31:16]` and `yi = i_vtx_y[31:16]`, both signed 16-bit. The fraction is ignored.
- **Edge k (from vertex k to vertex k+1 mod 3):**
  - A = y_k − y_(k+1)
  - B = x_(k+1) − x_k
  - C = x_k·y_(k+1) − x_(k+1)·y_k
- **Area:** (x1−x0)(y2−y0) − (x2−x0)(y1−y0). Positive means front-facing.
- **Width:** the guard band guarantees no overflow in A, B, C or area.
- **Bounding box:** min/max of the vertex integer coordinates, clamped to [0, SCREEN_W−1] × [0, SCREEN_H−1].
- **States:**
  - **S_COLLECT:** `o_fifo_rd = !i_fifo_empty`. Each pop latches the vertex into slot `vcnt` and increments `vcnt`. The pop with `vcnt == 2` sets `vcnt` to 0 and moves to S_DELTA.
  - **S_DELTA:** register the deltas, the raw min/max values and the guard-band flag; go to S_SETUP.
  - **S_SETUP:** register the area, A/B/C and the clamped bounding box; go to S_DECIDE.
  - **S_DECIDE:** drop the triangle (increment `o_culled_count`, go to S_COLLECT) if any of these hold: guard-band violation, area == 0, unclamped max < 0, min.x ≥ SCREEN_W, or min.y ≥ SCREEN_H. Apply the culling rule from Configuration. Otherwise set `o_tri_valid` and go to S_EMIT.
  - **S_EMIT:** all outputs are held stable. On `o_tri_valid && i_tri_ready`, clear valid and go to S_COLLECT.
- **i_flush:** takes effect in any state. It clears `vcnt` and `o_tri_valid` and forces S_COLLECT; no pop occurs that cycle. A flush has priority over a simultaneous pop or handshake.
- **No pops** occur outside S_COLLECT, so the FIFO absorbs backpressure.

## Timing
- Let edge 0 be the clock edge that accepts the third vertex. The state is S_DELTA after edge 0, S_SETUP after edge 1 and S_DECIDE after edge 2. `o_tri_valid` is high after edge 3.
- The minimum interval between triangles is 7 cycles: 3 pops, 3 setup cycles and 1 handshake cycle.
- Collection resumes on the cycle after the handshake.
- On reset, every output is 0, the state is S_COLLECT and `vcnt` is 0.
- A reset mid-operation abandons the triangle in progress immediately. The vertices already popped are lost.
- `o_culled_count` holds at 0xFFFF once it saturates.

## Configuration
- **With `TRI_SETUP_BACKFACE_CULL_EN` defined:** triangles with area < 0 are dropped and counted.
- **Without it:** triangles with area < 0 are emitted with vertices 1 and 2 swapped. The edges, area, z, u and v are all recomputed or reordered accordingly, so `o_area` is always positive.
- The swap is selected combinationally in S_SETUP from the sign of the S_DELTA products, so latency is identical in both builds.

## Structure
- **Package `triangle_setup_pkg`:**
  - state enum;
  - `SCREEN_W`, `SCREEN_H` and `GUARD_BAND` defaults;
  - `vertex_t` packed struct with fields x, y, z, u, v.
- **Sub-module `triangle_bbox`:** combinational clamp and empty-box detection. Instantiated once.

## Test plan
1. **Front-facing triangle:** pixels v0(10,10), v1(50,10), v2(10,40).
   - Edge 0: A=0, B=40, C=−400.
   - Area = 1200; bbox = (10..50, 10..40).
   - `o_tri_valid` is high after edge 3.
2. **Back-facing triangle:** order v0, v2, v1.
   - With `TRI_SETUP_BACKFACE_CULL_EN`: dropped, `o_culled_count` = 1.
   - Without it: emitted with area 1200 and outputs identical to scenario 1.
3. **Rejects:** each of the following is dropped with no `o_tri_valid`, and `o_culled_count` increments once per case:
   - collinear (0,0), (10,10), (20,20);
   - all x in 400..500;
   - a vertex at x = 2048.
4. **Clamping:** v0(−20,−5), v1(400,10), v2(30,300) → bbox = (0..319, 0..239).
5. **Backpressure:** hold `i_tri_ready` low for 5 cycles while the FIFO holds vertices. All outputs stay stable and `o_fifo_rd` stays low. The next pop occurs the cycle after the handshake.
6. **Flush:** assert `i_flush` after 2 pops, then supply 3 vertices → exactly one triangle, built from the 3 new vertices.
7. **Reset mid-setup:** assert async `i_rst` during S_SETUP → outputs are 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/triangle_setup_pkg.sv
// triangle_setup_pkg: shared state encoding, screen defaults, vertex type and small helpers
package triangle_setup_pkg;
  localparam int SCREEN_W_DEFAULT   = 320;
  localparam int SCREEN_H_DEFAULT   = 240;
  localparam int GUARD_BAND_DEFAULT = 2048;

  typedef enum logic [2:0] {S_COLLECT, S_DELTA, S_SETUP, S_DECIDE, S_EMIT} state_t;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic [7:0]         z;
    logic [31:0]        u;
    logic [31:0]        v;
  } vertex_t;

  function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
    return a < b ? (a < c ? a : c) : (b < c ? b : c);
  endfunction

  function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction

  function automatic logic out_of_band(input logic signed [15:0] c, input int g);
    return c >= g || c <= -g;
  endfunction

  function automatic int nxt(input int k);
    return k == 2 ? 0 : k + 1;
  endfunction
endpackage

// File: rtl/triangle_bbox.sv
// triangle_bbox: clamps the raw vertex extent to the screen and flags extents that miss it entirely
module triangle_bbox
  import triangle_setup_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
  input  logic signed [15:0] i_xmin,
  input  logic signed [15:0] i_xmax,
  input  logic signed [15:0] i_ymin,
  input  logic signed [15:0] i_ymax,
  output logic [8:0]         o_xmin,
  output logic [8:0]         o_xmax,
  output logic [7:0]         o_ymin,
  output logic [7:0]         o_ymax,
  output logic               o_empty
);
  // Clamp each bound into the visible range; empty when the extent lies wholly off one side
  always_comb begin
    o_xmin  = i_xmin < 0 ? '0 : i_xmin >= SCREEN_W ? 9'(SCREEN_W - 1) : i_xmin[8:0];
    o_xmax  = i_xmax < 0 ? '0 : i_xmax >= SCREEN_W ? 9'(SCREEN_W - 1) : i_xmax[8:0];
    o_ymin  = i_ymin < 0 ? '0 : i_ymin >= SCREEN_H ? 8'(SCREEN_H - 1) : i_ymin[7:0];
    o_ymax  = i_ymax < 0 ? '0 : i_ymax >= SCREEN_H ? 8'(SCREEN_H - 1) : i_ymax[7:0];
    o_empty = i_xmax < 0 || i_ymax < 0 || i_xmin >= SCREEN_W || i_ymin >= SCREEN_H;
  end
endmodule

// File: rtl/triangle_setup.sv
// triangle_setup: assembles FIFO vertices into triangles, computes edges/area/bbox, culls, hands off; define TRI_SETUP_BACKFACE_CULL_EN to drop back-facing triangles instead of re-winding them
module triangle_setup
  import triangle_setup_pkg::*;
#(
  parameter int SCREEN_W   = SCREEN_W_DEFAULT,
  parameter int SCREEN_H   = SCREEN_H_DEFAULT,
  parameter int GUARD_BAND = GUARD_BAND_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd,
  input  logic [31:0]      i_vtx_x,
  input  logic [31:0]      i_vtx_y,
  input  logic [7:0]       i_vtx_z,
  input  logic [31:0]      i_vtx_u,
  input  logic [31:0]      i_vtx_v,
  output logic             o_tri_valid,
  input  logic             i_tri_ready,
  output logic [8:0]       o_bbox_xmin,
  output logic [8:0]       o_bbox_xmax,
  output logic [7:0]       o_bbox_ymin,
  output logic [7:0]       o_bbox_ymax,
  output logic [2:0][15:0] o_edge_a,
  output logic [2:0][15:0] o_edge_b,
  output logic [2:0][31:0] o_edge_c,
  output logic [31:0]      o_area,
  output logic [2:0][7:0]  o_z,
  output logic [2:0][31:0] o_u,
  output logic [2:0][31:0] o_v,
  output logic [15:0]      o_culled_count,
  output logic             o_busy
);
  state_t                 state_q;
  logic [1:0]             vcnt_q;
  vertex_t [2:0]          vtx_q, p, q;
  vertex_t                vin;
  logic signed [16:0]     dx1_q, dy1_q, dx2_q, dy2_q;
  logic signed [15:0]     xmin_q, xmax_q, ymin_q, ymax_q;
  logic signed [31:0]     area_w;
  logic [31:0]            area_q;
  logic [2:0][15:0]       a_d, b_d, a_q, b_q;
  logic [2:0][31:0]       c_d, c_q;
  logic [8:0]             bxmin_d, bxmax_d, bxmin_q, bxmax_q;
  logic [7:0]             bymin_d, bymax_d, bymin_q, bymax_q;
  logic [15:0]            cull_q;
  logic                   guard_d, guard_q, empty_d, empty_q, swap_d, swap_q, valid_q, back_cull, drop;
  logic                   unused_frac;

  assign vin         = '{x: i_vtx_x[31:16], y: i_vtx_y[31:16], z: i_vtx_z, u: i_vtx_u, v: i_vtx_v};
  assign unused_frac = ^{i_vtx_x[15:0], i_vtx_y[15:0]};
  assign o_fifo_rd   = !i_rst && !i_flush && state_q == S_COLLECT && !i_fifo_empty;
  assign o_busy      = state_q != S_COLLECT || vcnt_q != 2'd0;
  assign guard_d     = out_of_band(vtx_q[0].x, GUARD_BAND) || out_of_band(vtx_q[0].y, GUARD_BAND) ||
                       out_of_band(vtx_q[1].x, GUARD_BAND) || out_of_band(vtx_q[1].y, GUARD_BAND) ||
                       out_of_band(vtx_q[2].x, GUARD_BAND) || out_of_band(vtx_q[2].y, GUARD_BAND);

  // Area from the registered deltas picks the winding; edges are then formed in output vertex order
  always_comb begin
    area_w = 32'(dx1_q) * 32'(dy2_q) - 32'(dx2_q) * 32'(dy1_q);
`ifdef TRI_SETUP_BACKFACE_CULL_EN
    swap_d = 1'b0;
`else
    swap_d = area_w < 0;
`endif
    p = {swap_d ? vtx_q[1] : vtx_q[2], swap_d ? vtx_q[2] : vtx_q[1], vtx_q[0]};
    for (int k = 0; k < 3; k++) begin
      a_d[k] = p[k].y - p[nxt(k)].y;
      b_d[k] = p[nxt(k)].x - p[k].x;
      c_d[k] = 32'($signed(p[k].x)) * 32'($signed(p[nxt(k)].y)) - 32'($signed(p[nxt(k)].x)) * 32'($signed(p[k].y));
    end
  end

  triangle_bbox #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_bbox (
    .i_xmin(xmin_q), .i_xmax(xmax_q), .i_ymin(ymin_q), .i_ymax(ymax_q),
    .o_xmin(bxmin_d), .o_xmax(bxmax_d), .o_ymin(bymin_d), .o_ymax(bymax_d), .o_empty(empty_d)
  );

`ifdef TRI_SETUP_BACKFACE_CULL_EN
  assign back_cull = area_q[31];
`else
  assign back_cull = 1'b0;
`endif
  assign drop = guard_q || area_q == '0 || empty_q || back_cull;

  // Sequencer: collect three vertices, two setup steps, cull decision, then hold until accepted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_COLLECT;
      vcnt_q  <= '0;
      vtx_q   <= '0;
      {dx1_q, dy1_q, dx2_q, dy2_q} <= '0;
      {xmin_q, xmax_q, ymin_q, ymax_q} <= '0;
      {guard_q, empty_q, swap_q, valid_q} <= '0;
      area_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      {bxmin_q, bxmax_q, bymin_q, bymax_q} <= '0;
      cull_q  <= '0;
    end else if (i_flush) begin
      state_q <= S_COLLECT;
      vcnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_COLLECT: if (!i_fifo_empty) begin
          vtx_q[vcnt_q] <= vin;
          vcnt_q  <= vcnt_q == 2'd2 ? 2'd0 : vcnt_q + 2'd1;
          state_q <= vcnt_q == 2'd2 ? S_DELTA : S_COLLECT;
        end
        S_DELTA: begin
          dx1_q   <= 17'($signed(vtx_q[1].x)) - 17'($signed(vtx_q[0].x));
          dy1_q   <= 17'($signed(vtx_q[1].y)) - 17'($signed(vtx_q[0].y));
          dx2_q   <= 17'($signed(vtx_q[2].x)) - 17'($signed(vtx_q[0].x));
          dy2_q   <= 17'($signed(vtx_q[2].y)) - 17'($signed(vtx_q[0].y));
          xmin_q  <= min3(vtx_q[0].x, vtx_q[1].x, vtx_q[2].x);
          xmax_q  <= max3(vtx_q[0].x, vtx_q[1].x, vtx_q[2].x);
          ymin_q  <= min3(vtx_q[0].y, vtx_q[1].y, vtx_q[2].y);
          ymax_q  <= max3(vtx_q[0].y, vtx_q[1].y, vtx_q[2].y);
          guard_q <= guard_d;
          state_q <= S_SETUP;
        end
        S_SETUP: begin
          area_q  <= swap_d ? -area_w : area_w;
          swap_q  <= swap_d;
          a_q     <= a_d;
          b_q     <= b_d;
          c_q     <= c_d;
          {bxmin_q, bxmax_q, bymin_q, bymax_q} <= {bxmin_d, bxmax_d, bymin_d, bymax_d};
          empty_q <= empty_d;
          state_q <= S_DECIDE;
        end
        S_DECIDE: begin
          cull_q  <= drop && cull_q != 16'hFFFF ? cull_q + 16'd1 : cull_q;
          valid_q <= !drop;
          state_q <= drop ? S_COLLECT : S_EMIT;
        end
        S_EMIT: if (i_tri_ready) begin
          valid_q <= 1'b0;
          state_q <= S_COLLECT;
        end
        default: state_q <= S_COLLECT;
      endcase
    end
  end

  assign q              = {swap_q ? vtx_q[1] : vtx_q[2], swap_q ? vtx_q[2] : vtx_q[1], vtx_q[0]};
  assign o_z            = {q[2].z, q[1].z, q[0].z};
  assign o_u            = {q[2].u, q[1].u, q[0].u};
  assign o_v            = {q[2].v, q[1].v, q[0].v};
  assign o_tri_valid    = valid_q;
  assign o_area         = area_q;
  assign o_edge_a       = a_q;
  assign o_edge_b       = b_q;
  assign o_edge_c       = c_q;
  assign o_bbox_xmin    = bxmin_q;
  assign o_bbox_xmax    = bxmax_q;
  assign o_bbox_ymin    = bymin_q;
  assign o_bbox_ymax    = bymax_q;
  assign o_culled_count = cull_q;
endmodule
